// File: rtl/timer_dev_pkg.sv
// Shared definitions for the countdown timer: register offsets, FSM states,
// MODE codes and CTRL bit positions.
package timer_dev_pkg;

  localparam logic [1:0] TIMER_CTRL   = 2'b00;
  localparam logic [1:0] TIMER_PRESET = 2'b01;
  localparam logic [1:0] TIMER_COUNT  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } timer_state_e;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_PSC_LO  = 4;

  // Only 01 reloads; 00 and the unused 1x codes both behave as one-shot.
  function automatic logic is_reload(input logic [1:0] mode);
    return (mode == MODE_RELOAD) && (mode != MODE_ONESHOT);
  endfunction

endpackage

// File: rtl/timer_dev_if.sv
// CPU-bridge responder port of one timer instance, plus the FSM state for observation.
interface timer_dev_if;
  import timer_dev_pkg::*;

  // Single-cycle bus: no valid/ready handshake. A write happens on every rising
  // edge where we=1; dout is a pure combinational function of addr[3:2].
  logic [31:2]  addr;
  logic         we;
  logic [31:0]  din;
  logic [31:0]  dout;
  logic         irq;
  timer_state_e dbg_state;

  modport master (output addr, we, din, input dout, irq, dbg_state);
  modport slave  (input addr, we, din, output dout, irq, dbg_state);

endinterface

// File: rtl/timer_prescaler.sv
// Divides the countdown rate: tick pulses once every 2^psc cycles while run is high.
module timer_prescaler #(
  parameter int PSC_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             run,
  input  logic [PSC_W-1:0] psc,
  output logic             tick
);

  localparam int CW = 1 << PSC_W;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] limit;

  assign limit = (CW'(1) << psc) - CW'(1);
  assign tick  = run && (cnt_q == limit);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/timer_dev.sv
// Bus-slave countdown timer with CTRL/PRESET/COUNT registers and a registered IRQ.
// Optional prescaler on the countdown is enabled by defining TIMER_PRESCALE_EN.
module timer_dev
  import timer_dev_pkg::*;
#(
  parameter logic [31:0] RST_PRESET = 32'h0000_0000,
  parameter int          PRESCALE_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  timer_dev_if.slave  bus
);

  logic [31:0]  ctrl_q;
  logic [31:0]  preset_q;
  logic [31:0]  count_q;
  logic [31:0]  count_d;
  timer_state_e state_q;
  timer_state_e state_d;
  logic         irq_flag_q;
  logic         irq_flag_d;
  logic         irq_q;
  logic         clr_en;
  logic         tick;
  logic [1:0]   reg_sel;
  logic         wr_ctrl;
  logic         wr_preset;
  logic         en_cnt;
  logic [31:0]  dout_d;
  logic         unused_addr;

  assign reg_sel     = bus.addr[3:2];
  assign wr_ctrl     = bus.we && (reg_sel == TIMER_CTRL);
  assign wr_preset   = bus.we && (reg_sel == TIMER_PRESET);
  assign unused_addr = ^bus.addr[31:4];

  // A CTRL write landing this edge decides whether a running count continues.
  assign en_cnt = wr_ctrl ? bus.din[CTRL_EN] : ctrl_q[CTRL_EN];

`ifdef TIMER_PRESCALE_EN
  localparam logic [31:0] CTRL_MASK =
    32'hF | (((32'd1 << PRESCALE_W) - 32'd1) << CTRL_PSC_LO);

  timer_prescaler #(.PSC_W(PRESCALE_W)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   ((state_q == LOAD) || wr_ctrl),
    .run   (state_q == CNT),
    .psc   (ctrl_q[CTRL_PSC_LO +: PRESCALE_W]),
    .tick  (tick)
  );
`else
  localparam logic [31:0] CTRL_MASK = 32'hF;
  logic [PRESCALE_W-1:0] unused_psc;

  assign unused_psc = '0;
  assign tick       = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    clr_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_q[CTRL_EN]) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en_cnt) begin
          state_d = IDLE;
        end else if (tick) begin
          if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
          end else begin
            count_d    = '0;
            irq_flag_d = 1'b1;
            state_d    = INT;
          end
        end
      end
      INT: begin
        if (is_reload(ctrl_q[CTRL_MODE_LO +: 2])) begin
          state_d    = LOAD;
          irq_flag_d = 1'b0;
        end else begin
          clr_en  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (wr_ctrl || wr_preset) irq_flag_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      preset_q   <= RST_PRESET;
      count_q    <= '0;
      state_q    <= IDLE;
      irq_flag_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
      irq_q      <= irq_flag_q & ctrl_q[CTRL_IM];
      // The bus write overrides the one-shot EN clear, EN included.
      if (wr_ctrl) begin
        ctrl_q <= bus.din & CTRL_MASK;
      end else if (clr_en) begin
        ctrl_q[CTRL_EN] <= 1'b0;
      end
      if (wr_preset) preset_q <= bus.din;
    end
  end

  always_comb begin
    dout_d = '0;
    case (reg_sel)
      TIMER_CTRL:   dout_d = ctrl_q;
      TIMER_PRESET: dout_d = preset_q;
      TIMER_COUNT:  dout_d = count_q;
      default:      dout_d = '0;
    endcase
  end

  assign bus.dout      = dout_d;
  assign bus.irq       = irq_q;
  assign bus.dbg_state = state_q;

endmodule
